// File: rtl/fft_pkg.sv
// Shared arithmetic helpers and twiddle generation for the streaming FFT.
// Kept width-agnostic so every stage can reuse them with its own parameters.
package fft_pkg;

  typedef struct packed {
    int re;
    int im;
  } cplx_int_t;

  function automatic int sat_to(input int v, input int w);
    int mx;
    int mn;
    mx = (1 <<< (w - 1)) - 1;
    mn = -mx - 1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  function automatic int rshift_rnd(
    input int v,
    input int sh,
    input bit rnd
  );
    int bias;
    bias = rnd ? (1 <<< (sh - 1)) : 0;
    return (v + bias) >>> sh;
  endfunction

  // {re, im} as two 32-bit fields, each clipped to the twiddle range
  function automatic logic [63:0] twiddle_entry(
    input int k,
    input int n,
    input int tw_w
  );
    real pi_v;
    real ang;
    real sc;
    int  c;
    int  s;
    int  mx;
    int  mn;
    pi_v = 3.14159265358979323846;
    ang  = 2.0 * pi_v * real'(k) / real'(n);
    sc   = real'(1 <<< (tw_w - 1));
    c    = int'(sc * $cos(ang));
    s    = int'(-sc * $sin(ang));
    mx   = (1 <<< (tw_w - 1)) - 1;
    mn   = -mx - 1;
    if (c > mx) c = mx;
    if (c < mn) c = mn;
    if (s > mx) s = mx;
    if (s < mn) s = mn;
    return {c, s};
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Registered twiddle ROM: W^k = exp(-j*2*pi*k/N), filled at elaboration.
// Read advances only with the pipeline enable so it stays aligned with S1.
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int TW_W      = 8,
  parameter int TW_ADDR_W = 3
) (
  input  logic                   clock_c,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic [TW_ADDR_W-1:0]   addr,
  output logic signed [TW_W-1:0] w_re,
  output logic signed [TW_W-1:0] w_im
);

  localparam int DEPTH = 1 << TW_ADDR_W;
  localparam int N     = 2 * DEPTH;

  logic signed [TW_W-1:0] tbl_re [DEPTH];
  logic signed [TW_W-1:0] tbl_im [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
    localparam logic [63:0] ENT = twiddle_entry(k, N, TW_W);
    assign tbl_re[k] = TW_W'(ENT[63:32]);
    assign tbl_im[k] = TW_W'(ENT[31:0]);
  end

  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      w_re <= '0;
      w_im <= '0;
    end else if (en) begin
      w_re <= tbl_re[addr];
      w_im <= tbl_im[addr];
    end
  end

endmodule

// File: rtl/fft_bfly_r2_pipe.sv
// Four-stage radix-2 DIT butterfly: X = A + B*W^k, Y = A - B*W^k.
// Per-beat inverse/scale modes, saturating arithmetic, sticky overflow.
module fft_bfly_r2_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TW_W      = 8,
  parameter int TW_ADDR_W = 3,
  parameter int ROUND     = 1
) (
  input  logic                  clock_c,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DATA_W-1:0]   in_a,
  input  logic [2*DATA_W-1:0]   in_b,
  input  logic [TW_ADDR_W-1:0]  in_tw_idx,
  input  logic                  in_inv,
  input  logic                  in_scale,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   out_x,
  output logic [2*DATA_W-1:0]   out_y,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int T_W = DATA_W + 1;
  localparam bit RND = (ROUND != 0);

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic  v;
    cplx_t a;
    cplx_t b;
    logic  inv;
    logic  scale;
  } s1_t;

  typedef struct packed {
    logic                     v;
    cplx_t                    a;
    logic signed [DATA_W-1:0] rr;
    logic signed [DATA_W-1:0] ii;
    logic signed [DATA_W-1:0] ri;
    logic signed [DATA_W-1:0] ir;
    logic                     scale;
  } s2_t;

  typedef struct packed {
    logic                  v;
    cplx_t                 a;
    logic signed [T_W-1:0] tre;
    logic signed [T_W-1:0] tim;
    logic                  scale;
  } s3_t;

  logic en;
  s1_t  s1_q;
  s2_t  s2_q;
  s2_t  s2_d;
  s3_t  s3_q;
  s3_t  s3_d;
  cplx_t x_d;
  cplx_t y_d;
  logic s2_clamp;
  logic s4_clamp;
  logic ovf_set;

  logic signed [TW_W-1:0] w_re;
  logic signed [TW_W-1:0] w_im;

  int wi_eff;
  int rr_f, ii_f, ri_f, ir_f;
  int rr_s, ii_s, ri_s, ir_s;
  int xr_f, xi_f, yr_f, yi_f;
  int xr_s, xi_s, yr_s, yi_s;
  int tre_f, tim_f;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  fft_twiddle_rom #(
    .TW_W      (TW_W),
    .TW_ADDR_W (TW_ADDR_W)
  ) u_rom (
    .clock_c (clock_c),
    .reset_n (reset_n),
    .en      (en),
    .addr    (in_tw_idx),
    .w_re    (w_re),
    .w_im    (w_im)
  );

  // conj(W) for inverse beats; -(-2^(TW_W-1)) clips to the max
  always_comb begin
    wi_eff = int'(w_im);
    if (s1_q.inv) wi_eff = sat_to(-wi_eff, TW_W);
    rr_f = rshift_rnd(int'(s1_q.b.re) * int'(w_re), TW_W - 1, RND);
    ii_f = rshift_rnd(int'(s1_q.b.im) * wi_eff, TW_W - 1, RND);
    ri_f = rshift_rnd(int'(s1_q.b.re) * wi_eff, TW_W - 1, RND);
    ir_f = rshift_rnd(int'(s1_q.b.im) * int'(w_re), TW_W - 1, RND);
    rr_s = sat_to(rr_f, DATA_W);
    ii_s = sat_to(ii_f, DATA_W);
    ri_s = sat_to(ri_f, DATA_W);
    ir_s = sat_to(ir_f, DATA_W);
    s2_clamp = (rr_s != rr_f) || (ii_s != ii_f) ||
               (ri_s != ri_f) || (ir_s != ir_f);
    s2_d.v     = s1_q.v;
    s2_d.a     = s1_q.a;
    s2_d.rr    = DATA_W'(rr_s);
    s2_d.ii    = DATA_W'(ii_s);
    s2_d.ri    = DATA_W'(ri_s);
    s2_d.ir    = DATA_W'(ir_s);
    s2_d.scale = s1_q.scale;
  end

  always_comb begin
    tre_f      = int'(s2_q.rr) - int'(s2_q.ii);
    tim_f      = int'(s2_q.ri) + int'(s2_q.ir);
    s3_d.v     = s2_q.v;
    s3_d.a     = s2_q.a;
    s3_d.tre   = T_W'(tre_f);
    s3_d.tim   = T_W'(tim_f);
    s3_d.scale = s2_q.scale;
  end

  always_comb begin
    xr_f = int'(s3_q.a.re) + int'(s3_q.tre);
    xi_f = int'(s3_q.a.im) + int'(s3_q.tim);
    yr_f = int'(s3_q.a.re) - int'(s3_q.tre);
    yi_f = int'(s3_q.a.im) - int'(s3_q.tim);
    if (s3_q.scale) begin
      xr_f = rshift_rnd(xr_f, 1, 1'b1);
      xi_f = rshift_rnd(xi_f, 1, 1'b1);
      yr_f = rshift_rnd(yr_f, 1, 1'b1);
      yi_f = rshift_rnd(yi_f, 1, 1'b1);
    end
    xr_s = sat_to(xr_f, DATA_W);
    xi_s = sat_to(xi_f, DATA_W);
    yr_s = sat_to(yr_f, DATA_W);
    yi_s = sat_to(yi_f, DATA_W);
    s4_clamp = (xr_s != xr_f) || (xi_s != xi_f) ||
               (yr_s != yr_f) || (yi_s != yi_f);
    x_d.re = DATA_W'(xr_s);
    x_d.im = DATA_W'(xi_s);
    y_d.re = DATA_W'(yr_s);
    y_d.im = DATA_W'(yi_s);
  end

  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (en) begin
      s1_q.v     <= in_valid;
      s1_q.a     <= in_a;
      s1_q.b     <= in_b;
      s1_q.inv   <= in_inv;
      s1_q.scale <= in_scale;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      out_valid  <= s3_q.v;
      out_x      <= x_d;
      out_y      <= y_d;
    end
  end

  assign ovf_set = en && ((s1_q.v && s2_clamp) ||
                          (s3_q.v && s4_clamp));

  // a new clamp outranks a clear arriving on the same edge
  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule
